// File: rtl/arm_control_fsm_pkg.sv
// rtl/arm_control_fsm_pkg.sv - shared types and constants for the ARM control sequencer
package arm_ctrl_pkg;

    localparam int CTRL_STATE_W        = 3;
    localparam int MEM_TIMEOUT_DEFAULT = 15;

    typedef enum logic [CTRL_STATE_W-1:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } ctrl_state_t;

endpackage

// File: rtl/arm_control_fsm_if.sv
// rtl/arm_control_fsm_if.sv - instruction/data memory request/ready handshake bundle
interface arm_control_fsm_if;

    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output dmem_ready
    );

endinterface

// File: rtl/arm_mem_timer.sv
// rtl/arm_mem_timer.sv - clearable request-cycle counter shared by the fetch and data waits
module arm_mem_timer
    import arm_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (count_en) begin
            count_q <= count_q + W'(1);
        end
    end

    // count_q holds completed empty request cycles, so this fires during request cycle MEM_TIMEOUT
    assign expired = (MEM_TIMEOUT != 0) && count_en && (count_q == W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/arm_control_fsm.sv
// rtl/arm_control_fsm.sv - multi-cycle fetch/decode/exec/mem/writeback sequencer with commit strobes
module arm_control_fsm
    import arm_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int CNT_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    arm_control_fsm_if.master       mem,
    input  logic                    dec_reg_we,
    input  logic [3:0]              dec_cpsr_mask,
    input  logic                    dec_swi,
    input  logic                    dec_is_load,
    input  logic                    dec_is_store,
    input  logic                    dec_is_branch,
    input  logic                    cond_pass,
    output logic                    ir_we,
    output logic                    pc_we,
    output logic                    pc_sel_branch,
    output logic                    rf_we,
    output logic [3:0]              cpsr_we,
    output logic                    halted,
    output logic                    mem_fault,
    output logic [CNT_W-1:0]        retired,
    output logic [CTRL_STATE_W-1:0] state
);

    ctrl_state_t      state_q;
    logic [CNT_W-1:0] retired_q;
    logic             halted_q;
    logic             fault_q;

    logic wait_state;
    logic ready_now;
    logic waiting;
    logic expired;
    logic retire;
    logic imem_req_c;
    logic dmem_req_c;
    logic dmem_we_c;

    assign wait_state = (state_q == S_FETCH) || (state_q == S_MEM);
    assign ready_now  = (state_q == S_FETCH) ? mem.imem_ready : mem.dmem_ready;
    assign waiting    = wait_state && !ready_now;

    // Every wait state is left through a ready or a fault, so clearing outside empty waits resets on entry
    arm_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!waiting),
        .count_en(waiting),
        .expired (expired)
    );

    assign retire = ((state_q == S_DECODE) && dec_swi && cond_pass)
                 || ((state_q == S_EXEC) && !cond_pass)
                 || ((state_q == S_MEM) && mem.dmem_ready && dec_is_store)
                 || (state_q == S_WB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            case (state_q)
                S_FETCH: begin
                    if (mem.imem_ready) begin
                        state_q <= S_DECODE;
                    end else if (expired) begin
                        state_q <= S_FAULT;
                        fault_q <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (dec_swi && cond_pass) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!cond_pass) begin
                        state_q <= S_FETCH;
                    end else if (dec_is_load || dec_is_store) begin
                        state_q <= S_MEM;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem.dmem_ready) begin
                        state_q <= dec_is_store ? S_FETCH : S_WB;
                    end else if (expired) begin
                        state_q <= S_FAULT;
                        fault_q <= 1'b1;
                    end
                end
                S_WB:    state_q <= S_FETCH;
                S_HALT:  state_q <= S_HALT;
                S_FAULT: state_q <= S_FAULT;
                default: begin
                    state_q <= S_FAULT;
                    fault_q <= 1'b1;
                end
            endcase
        end
    end

    // Strobes are Mealy on ready and held low for the whole time reset is asserted
    always_comb begin
        imem_req_c    = 1'b0;
        dmem_req_c    = 1'b0;
        dmem_we_c     = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        pc_sel_branch = 1'b0;
        rf_we         = 1'b0;
        cpsr_we       = 4'h0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    imem_req_c = 1'b1;
                    ir_we      = mem.imem_ready;
                end
                S_EXEC: begin
                    pc_we = !cond_pass;
                end
                S_MEM: begin
                    dmem_req_c = 1'b1;
                    dmem_we_c  = dec_is_store;
                    pc_we      = mem.dmem_ready && dec_is_store;
                end
                S_WB: begin
                    rf_we         = dec_reg_we;
                    cpsr_we       = dec_cpsr_mask;
                    pc_we         = 1'b1;
                    pc_sel_branch = dec_is_branch;
                end
                default: ;
            endcase
        end
    end

    assign mem.imem_req = imem_req_c;
    assign mem.dmem_req = dmem_req_c;
    assign mem.dmem_we  = dmem_we_c;
    assign halted       = halted_q;
    assign mem_fault    = fault_q;
    assign retired      = retired_q;
    assign state        = state_q;

endmodule
